// File: rtl/i2c_reg_seq_pkg.sv
// Shared I2C command codes plus the sequencer and issuer state encodings.
// The command codes must stay in step with the byte-level I2C master.
package i2c_reg_seq_pkg;
  localparam logic [2:0] k_START_CMD   = 3'd0;
  localparam logic [2:0] k_RESTART_CMD = 3'd1;
  localparam logic [2:0] k_STOP_CMD    = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_WRITE_CMD   = 3'd4;

  localparam logic [3:0] k_seq_IDLE    = 4'd0;
  localparam logic [3:0] k_seq_START   = 4'd1;
  localparam logic [3:0] k_seq_DEV_W   = 4'd2;
  localparam logic [3:0] k_seq_REG     = 4'd3;
  localparam logic [3:0] k_seq_WDATA   = 4'd4;
  localparam logic [3:0] k_seq_RESTART = 4'd5;
  localparam logic [3:0] k_seq_DEV_R   = 4'd6;
  localparam logic [3:0] k_seq_READ    = 4'd7;
  localparam logic [3:0] k_seq_STOP    = 4'd8;
  localparam logic [3:0] k_seq_RESP    = 4'd9;

  localparam logic [1:0] k_iss_IDLE  = 2'd0;
  localparam logic [1:0] k_iss_ISSUE = 2'd1;
  localparam logic [1:0] k_iss_BUSY  = 2'd2;
  localparam logic [1:0] k_iss_DONE  = 2'd3;

  // The single read byte is always the last one, so the master NACKs it.
  localparam logic [7:0] k_READ_LAST_BYTE = 8'h01;
endpackage

// File: rtl/i2c_cmd_issuer.sv
// Hands one command to the I2C master (ISSUE/BUSY/DONE) and samples its result.
// Optional watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_issuer
  import i2c_reg_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] cmd,
  input  logic [7:0] data,
  output logic       done,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       timeout,
  output logic       m_write,
  output logic [2:0] m_cmd,
  output logic [7:0] m_data_in,
  input  logic       m_ready,
  input  logic       m_ack,
  input  logic [7:0] m_data_out
);
  logic [1:0] state;
  logic       expired;

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;

  assign expired = (state != k_iss_IDLE) && (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wd_cnt <= '0;
    else if (state == k_iss_IDLE && go) wd_cnt <= '0;
    else if (state != k_iss_IDLE)       wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ (TIMEOUT_W == 0);
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= k_iss_IDLE;
      done      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      timeout   <= 1'b0;
      m_write   <= 1'b0;
      m_cmd     <= '0;
      m_data_in <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      m_write <= 1'b0;
      case (state)
        k_iss_IDLE: if (go) begin
          m_cmd     <= cmd;
          m_data_in <= data;
          if (m_ready) begin
            m_write <= 1'b1;
            state   <= k_iss_BUSY;
          end else begin
            state <= k_iss_ISSUE;
          end
        end
        k_iss_ISSUE: if (m_ready) begin
          m_write <= 1'b1;
          state   <= k_iss_BUSY;
        end
        // m_ready may stay high a few cycles after the strobe; only its fall counts.
        k_iss_BUSY: if (!m_ready) state <= k_iss_DONE;
        default: if (m_ready) begin
          done  <= 1'b1;
          ack   <= m_ack;
          rdata <= m_data_out;
          state <= k_iss_IDLE;
        end
      endcase
      if (expired) begin
        timeout <= 1'b1;
        done    <= 1'b0;
        m_write <= 1'b0;
        state   <= k_iss_IDLE;
      end
    end
  end
endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer: one host request becomes the I2C master command stream.
// Optional watchdog abort enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_reg_seq
  import i2c_reg_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic       m_write,
  output logic [2:0] m_cmd,
  output logic [7:0] m_data_in,
  input  logic       m_ready,
  input  logic       m_ack,
  input  logic [7:0] m_data_out
);
  logic [3:0] state, nxt;
  logic       rnw, nack_seen, go, launch, accept, is_wr_state;
  logic [6:0] dev;
  logic [7:0] reg_addr, wdata, rd_byte, cmd_data, nxt_data, rdata;
  logic [2:0] cmd, nxt_cmd;
  logic       done, ack, timeout;

  i2c_cmd_issuer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_W(TIMEOUT_W)) u_issuer (
    .clk(clk), .reset(reset), .go(go), .cmd(cmd), .data(cmd_data),
    .done(done), .ack(ack), .rdata(rdata), .timeout(timeout),
    .m_write(m_write), .m_cmd(m_cmd), .m_data_in(m_data_in),
    .m_ready(m_ready), .m_ack(m_ack), .m_data_out(m_data_out)
  );

  assign accept      = req_valid && req_ready;
  assign is_wr_state = (state == k_seq_DEV_W) || (state == k_seq_REG) ||
                       (state == k_seq_WDATA) || (state == k_seq_DEV_R);

  always_comb begin
    nxt = state;
    case (state)
      k_seq_IDLE:    if (accept) nxt = k_seq_START;
      k_seq_START:   if (done) nxt = k_seq_DEV_W;
      k_seq_DEV_W:   if (done) nxt = ack ? k_seq_STOP : k_seq_REG;
      k_seq_REG:     if (done) nxt = ack ? k_seq_STOP : (rnw ? k_seq_RESTART : k_seq_WDATA);
      k_seq_WDATA:   if (done) nxt = k_seq_STOP;
      k_seq_RESTART: if (done) nxt = k_seq_DEV_R;
      k_seq_DEV_R:   if (done) nxt = ack ? k_seq_STOP : k_seq_READ;
      k_seq_READ:    if (done) nxt = k_seq_STOP;
      k_seq_STOP:    if (done) nxt = k_seq_RESP;
      default:       nxt = k_seq_IDLE;
    endcase
    // A stuck master cannot be trusted with a STOP, so abort straight to the response.
    if (timeout) nxt = k_seq_RESP;

    nxt_cmd  = k_STOP_CMD;
    nxt_data = '0;
    case (nxt)
      k_seq_START:   nxt_cmd = k_START_CMD;
      k_seq_DEV_W:   begin nxt_cmd = k_WRITE_CMD; nxt_data = {dev, 1'b0}; end
      k_seq_REG:     begin nxt_cmd = k_WRITE_CMD; nxt_data = reg_addr; end
      k_seq_WDATA:   begin nxt_cmd = k_WRITE_CMD; nxt_data = wdata; end
      k_seq_RESTART: nxt_cmd = k_RESTART_CMD;
      k_seq_DEV_R:   begin nxt_cmd = k_WRITE_CMD; nxt_data = {dev, 1'b1}; end
      k_seq_READ:    begin nxt_cmd = k_READ_CMD; nxt_data = k_READ_LAST_BYTE; end
      default:       nxt_cmd = k_STOP_CMD;
    endcase
    launch = (nxt != state) && (nxt != k_seq_IDLE) && (nxt != k_seq_RESP);
  end

  always_ff @(posedge clk) begin
    if (state == k_seq_IDLE && accept) begin
      rnw      <= req_rnw;
      dev      <= req_dev_addr;
      reg_addr <= req_reg_addr;
      wdata    <= req_wdata;
      rd_byte  <= '0;
    end else if (state == k_seq_READ && done) begin
      rd_byte <= rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= k_seq_IDLE;
      req_ready   <= 1'b0;
      nack_seen   <= 1'b0;
      go          <= 1'b0;
      cmd         <= '0;
      cmd_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= nxt;
      req_ready <= (nxt == k_seq_IDLE);
      go        <= launch;
      if (launch) begin
        cmd      <= nxt_cmd;
        cmd_data <= nxt_data;
      end
      if (state == k_seq_IDLE && accept)   nack_seen <= 1'b0;
      else if (is_wr_state && done && ack) nack_seen <= 1'b1;
      rsp_valid <= 1'b0;
      if (nxt == k_seq_RESP && state != k_seq_RESP) begin
        rsp_valid   <= 1'b1;
        rsp_timeout <= timeout;
        rsp_nack    <= !timeout && nack_seen;
        rsp_rdata   <= (!timeout && rnw && !nack_seen) ? rd_byte : 8'h00;
      end
    end
  end
endmodule
